issue_queue: RTL and testbench



---
 rtl/issue_queue.sv | 244 ++++++++++++++++++++++++
 tb/tb_issue_queue.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// issue_queue: in-order issue buffer between decode and the RS / SLB.
//
// Decoded instructions are written at the tail with their operands resolved
// from the RF tags, the ROB lookup and the CDBs of the same cycle. Queued
// operands that are still pending keep snooping the CDBs every cycle. The
// head entry is offered to the RS (or the SLB for load/store ops). It pops
// only when the ROB and the selected target can both take it.
//
// Ports
//   clk, rst (sync, active-low), rdy (global enable), flush
//   in_*       : decoded instruction and RF operand state; in_ready back
//   rob_rs*_*  : ROB result lookup for the in_qj/in_qk tags
//   cdb_*      : NCDB flattened broadcast buses
//   *_full     : target backpressure; next_robid is the ROB tail id
//   *_send_enable, send_robid : dispatch strobes / allocated ROB id
//   out_*, vj/qj/rj, vk/qk/rk : head instruction with same-cycle CDB bypass
module issue_queue #(
  parameter int DEPTH        = 4,
  parameter int ROB_SIZE_LOG = 4,
  parameter int OP_SIZE_LOG  = 6,
  parameter int NCDB         = 2,
  parameter int LS_OP_LO     = 10,
  parameter int LS_OP_HI     = 17
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_SIZE_LOG-1:0]       in_op,
  input  logic [4:0]                   in_rd,
  input  logic [31:0]                  in_imm,
  input  logic [31:0]                  in_pc,
  input  logic [31:0]                  in_vj,
  input  logic [31:0]                  in_vk,
  input  logic [ROB_SIZE_LOG-1:0]      in_qj,
  input  logic [ROB_SIZE_LOG-1:0]      in_qk,
  input  logic                         in_rj,
  input  logic                         in_rk,
  input  logic                         rob_rs1_ready,
  input  logic                         rob_rs2_ready,
  input  logic [31:0]                  rob_rs1_value,
  input  logic [31:0]                  rob_rs2_value,
  input  logic [NCDB-1:0]              cdb_valid,
  input  logic [NCDB*ROB_SIZE_LOG-1:0] cdb_robid,
  input  logic [NCDB*32-1:0]           cdb_value,
  input  logic                         rob_full,
  input  logic                         rs_full,
  input  logic                         slb_full,
  input  logic [ROB_SIZE_LOG-1:0]      next_robid,
  output logic                         rob_send_enable,
  output logic                         rf_send_enable,
  output logic                         rs_send_enable,
  output logic                         slb_send_enable,
  output logic [ROB_SIZE_LOG-1:0]      send_robid,
  output logic [OP_SIZE_LOG-1:0]       out_op,
  output logic [4:0]                   out_rd,
  output logic [31:0]                  out_imm,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  vj,
  output logic [ROB_SIZE_LOG-1:0]      qj,
  output logic                         rj,
  output logic [31:0]                  vk,
  output logic [ROB_SIZE_LOG-1:0]      qk,
  output logic                         rk
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [OP_SIZE_LOG-1:0]  op;
    logic [4:0]              rd;
    logic [31:0]             imm;
    logic [31:0]             pc;
    logic [31:0]             vj;
    logic [ROB_SIZE_LOG-1:0] qj;
    logic                    rj;
    logic [31:0]             vk;
    logic [ROB_SIZE_LOG-1:0] qk;
    logic                    rk;
  } entry_t;

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        ent_arr [DEPTH];
  entry_t        enq_ent, head_ent;
  logic          push, pop, nonempty, head_live, is_ls;
  logic [32:0]   enq_j_hit, enq_k_hit, head_j_hit, head_k_hit;

  // {hit, value} for a tag; scanning downward lets the lowest bus win.
  function automatic logic [32:0] cdb_lookup(input logic [ROB_SIZE_LOG-1:0] tag);
    logic [32:0] res;
    res = '0;
    for (int i = NCDB - 1; i >= 0; i--) begin
      if (cdb_valid[i] && cdb_robid[i*ROB_SIZE_LOG +: ROB_SIZE_LOG] == tag)
        res = {1'b1, cdb_value[i*32 +: 32]};
    end
    return res;
  endfunction

  // Operand resolution for the incoming instruction.
  always_comb begin
    enq_j_hit   = cdb_lookup(in_qj);
    enq_k_hit   = cdb_lookup(in_qk);
    enq_ent     = '0;
    enq_ent.op  = in_op;
    enq_ent.rd  = in_rd;
    enq_ent.imm = in_imm;
    enq_ent.pc  = in_pc;
    enq_ent.qj  = in_qj;
    enq_ent.qk  = in_qk;
    enq_ent.vj  = in_rj ? in_vj : rob_rs1_value;
    enq_ent.rj  = in_rj | rob_rs1_ready;
    enq_ent.vk  = in_rk ? in_vk : rob_rs2_value;
    enq_ent.rk  = in_rk | rob_rs2_ready;
    if (!enq_ent.rj && enq_j_hit[32]) begin
      enq_ent.vj = enq_j_hit[31:0];
      enq_ent.rj = 1'b1;
    end
    if (!enq_ent.rk && enq_k_hit[32]) begin
      enq_ent.vk = enq_k_hit[31:0];
      enq_ent.rk = 1'b1;
    end
  end

  // Head view, dispatch decision and handshakes.
  always_comb begin
    nonempty   = (count_q != '0);
    head_live  = rst && nonempty;
    head_ent   = ent_arr[head_q];
    head_j_hit = cdb_lookup(head_ent.qj);
    head_k_hit = cdb_lookup(head_ent.qk);
    is_ls      = (head_ent.op >= OP_SIZE_LOG'(LS_OP_LO)) &&
                 (head_ent.op <= OP_SIZE_LOG'(LS_OP_HI));
    pop        = rst && rdy && !flush && nonempty && !rob_full &&
                 (is_ls ? !slb_full : !rs_full);
    // A full queue refuses even when the head leaves in the same cycle.
    in_ready   = rst && rdy && !flush && (count_q != CW'(DEPTH));
    push       = in_valid && in_ready;

    rob_send_enable = pop;
    rf_send_enable  = pop;
    rs_send_enable  = pop && !is_ls;
    slb_send_enable = pop && is_ls;
    send_robid      = pop ? next_robid : '0;

    out_op  = '0;
    out_rd  = '0;
    out_imm = '0;
    out_pc  = '0;
    vj      = '0;
    qj      = '0;
    rj      = 1'b0;
    vk      = '0;
    qk      = '0;
    rk      = 1'b0;
    if (head_live) begin
      out_op  = head_ent.op;
      out_rd  = head_ent.rd;
      out_imm = head_ent.imm;
      out_pc  = head_ent.pc;
      qj      = head_ent.qj;
      qk      = head_ent.qk;
      // Same-cycle bypass so a broadcast during dispatch is not lost.
      rj      = head_ent.rj | head_j_hit[32];
      vj      = (!head_ent.rj && head_j_hit[32]) ? head_j_hit[31:0] : head_ent.vj;
      rk      = head_ent.rk | head_k_hit[32];
      vk      = (!head_ent.rk && head_k_hit[32]) ? head_k_hit[31:0] : head_ent.vk;
    end
  end

  always_comb begin
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(push);
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
      end
    end
  end

  // One storage slot per entry: CDB snoop on pending operands, write at tail.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    entry_t      ent_q, ent_d;
    logic        valid_q, valid_d;
    logic [32:0] j_hit, k_hit;

    always_comb begin
      ent_d   = ent_q;
      valid_d = valid_q;
      j_hit   = cdb_lookup(ent_q.qj);
      k_hit   = cdb_lookup(ent_q.qk);
      if (valid_q && !ent_q.rj && j_hit[32]) begin
        ent_d.vj = j_hit[31:0];
        ent_d.rj = 1'b1;
      end
      if (valid_q && !ent_q.rk && k_hit[32]) begin
        ent_d.vk = k_hit[31:0];
        ent_d.rk = 1'b1;
      end
      if (pop && head_q == AW'(gi))
        valid_d = 1'b0;
      if (push && tail_q == AW'(gi)) begin
        ent_d   = enq_ent;
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst)
        valid_q <= 1'b0;
      else if (rdy)
        valid_q <= flush ? 1'b0 : valid_d;
    end

    // Payload needs no reset: it is only observed while counted as occupied.
    always_ff @(posedge clk) begin
      if (rdy)
        ent_q <= ent_d;
    end

    assign ent_arr[gi] = ent_q;
  end
endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
  localparam int DEPTH = 4, RL = 4, OPW = 6, NCDB = 2, LSLO = 10, LSHI = 17;

  logic clk = 1'b0;
  logic rst, rdy, flush, in_valid, in_ready;
  logic [OPW-1:0] in_op;
  logic [4:0] in_rd;
  logic [31:0] in_imm, in_pc, in_vj, in_vk;
  logic [RL-1:0] in_qj, in_qk;
  logic in_rj, in_rk, rob_rs1_ready, rob_rs2_ready;
  logic [31:0] rob_rs1_value, rob_rs2_value;
  logic [NCDB-1:0] cdb_valid;
  logic [NCDB*RL-1:0] cdb_robid;
  logic [NCDB*32-1:0] cdb_value;
  logic rob_full, rs_full, slb_full;
  logic [RL-1:0] next_robid;
  logic rob_send_enable, rf_send_enable, rs_send_enable, slb_send_enable;
  logic [RL-1:0] send_robid, qj, qk;
  logic [OPW-1:0] out_op;
  logic [4:0] out_rd;
  logic [31:0] out_imm, out_pc, vj, vk;
  logic rj, rk;

  issue_queue #(.DEPTH(DEPTH), .ROB_SIZE_LOG(RL), .OP_SIZE_LOG(OPW), .NCDB(NCDB),
                .LS_OP_LO(LSLO), .LS_OP_HI(LSHI)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_imm(in_imm), .in_pc(in_pc), .in_vj(in_vj), .in_vk(in_vk),
    .in_qj(in_qj), .in_qk(in_qk), .in_rj(in_rj), .in_rk(in_rk),
    .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
    .rob_rs1_value(rob_rs1_value), .rob_rs2_value(rob_rs2_value),
    .cdb_valid(cdb_valid), .cdb_robid(cdb_robid), .cdb_value(cdb_value),
    .rob_full(rob_full), .rs_full(rs_full), .slb_full(slb_full), .next_robid(next_robid),
    .rob_send_enable(rob_send_enable), .rf_send_enable(rf_send_enable),
    .rs_send_enable(rs_send_enable), .slb_send_enable(slb_send_enable),
    .send_robid(send_robid), .out_op(out_op), .out_rd(out_rd), .out_imm(out_imm),
    .out_pc(out_pc), .vj(vj), .qj(qj), .rj(rj), .vk(vk), .qk(qk), .rk(rk));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic rf_r; logic [31:0] rf_v; logic rob_r; logic [31:0] rob_v;
    logic [1:0] cv; logic [3:0] t0; logic [31:0] c0; logic [3:0] t1; logic [31:0] c1;
    logic exp_r; logic [31:0] exp_v;
  } vec_t;
  vec_t vecs [8];

  typedef struct {
    logic [OPW-1:0] op; logic [4:0] rd; logic [31:0] imm, pc, vj, vk;
    logic [RL-1:0] qj, qk; logic rj, rk;
  } mrec_t;
  mrec_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cdb(input logic [1:0] cv, input logic [3:0] t0, input logic [31:0] c0,
                         input logic [3:0] t1, input logic [31:0] c1);
    cdb_valid = cv;
    cdb_robid = {t1, t0};
    cdb_value = {c1, c0};
  endtask

  task automatic idle();
    rst = 1; rdy = 1; flush = 0; in_valid = 0;
    in_op = '0; in_rd = '0; in_imm = '0; in_pc = '0; in_vj = '0; in_vk = '0;
    in_qj = '0; in_qk = '0; in_rj = 1; in_rk = 1;
    rob_rs1_ready = 0; rob_rs2_ready = 0; rob_rs1_value = '0; rob_rs2_value = '0;
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    rob_full = 0; rs_full = 0; slb_full = 0; next_robid = '0;
  endtask

  task automatic set_in(input logic [OPW-1:0] op, input logic [31:0] pc,
                        input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                        input logic r2, input logic [31:0] v2, input logic [3:0] t2);
    in_valid = 1; in_op = op; in_pc = pc; in_rd = pc[4:0]; in_imm = ~pc;
    in_rj = r1; in_vj = v1; in_qj = t1; in_rk = r2; in_vk = v2; in_qk = t2;
  endtask

  // Reference CDB lookup: first matching bus in ascending order.
  function automatic logic [32:0] ref_cdb(input logic [RL-1:0] tag);
    for (int i = 0; i < NCDB; i++)
      if (cdb_valid[i] && cdb_robid[i*RL +: RL] == tag) return {1'b1, cdb_value[i*32 +: 32]};
    return 33'd0;
  endfunction

  logic [32:0] hj, hk, h;
  logic        m_live, m_ls, m_go, m_rdy;
  mrec_t       hd, nr, t;
  logic [31:0] seq;

  initial begin
    vecs[0] = '{1, 32'hAAAA0001, 1, 32'hBBBB0002, 2'b00, 0, 0, 0, 0, 1, 32'hAAAA0001};
    vecs[1] = '{0, 32'hAAAA0001, 1, 32'hBBBB0002, 2'b00, 0, 0, 0, 0, 1, 32'hBBBB0002};
    vecs[2] = '{0, 32'hAAAA0001, 0, 32'hBBBB0002, 2'b00, 0, 0, 0, 0, 0, 32'hBBBB0002};
    vecs[3] = '{0, 32'hAAAA0001, 0, 32'hBBBB0002, 2'b01, 5, 32'hCCCC0003, 0, 0, 0, 32'hBBBB0002};
    vecs[4] = '{0, 32'hAAAA0001, 0, 32'hBBBB0002, 2'b10, 0, 0, 3, 32'hCCCC0003, 1, 32'hCCCC0003};
    vecs[5] = '{0, 32'hAAAA0001, 0, 32'hBBBB0002, 2'b11, 3, 32'hDDDD0004, 3, 32'hCCCC0003, 1, 32'hDDDD0004};
    vecs[6] = '{1, 32'hAAAA0001, 0, 32'hBBBB0002, 2'b01, 3, 32'hCCCC0003, 0, 0, 1, 32'hAAAA0001};
    vecs[7] = '{0, 32'hAAAA0001, 1, 32'hBBBB0002, 2'b01, 3, 32'hCCCC0003, 0, 0, 1, 32'hBBBB0002};

    // Reset: offered instruction must be ignored, outputs idle.
    idle();
    rst = 0;
    tick(); tick();
    set_in(6'd0, 32'h50, 1, 32'd1, 4'd0, 1, 32'd2, 4'd0);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rob_send", rob_send_enable, 0);
    chk("rst_send_robid", send_robid, 0);
    chk("rst_out_pc", out_pc, 0);
    tick();
    rst = 1; in_valid = 0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_empty", rob_send_enable, 0);
    chk("post_rst_pc", out_pc, 0);

    // Basic enqueue then dispatch a cycle later.
    set_in(6'd0, 32'd100, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0);
    next_robid = 4'd3;
    #1;
    chk("enq_no_passthru", rob_send_enable, 0);
    tick();
    in_valid = 0;
    #1;
    chk("disp_rs", rs_send_enable, 1);
    chk("disp_rob", rob_send_enable, 1);
    chk("disp_rf", rf_send_enable, 1);
    chk("disp_slb", slb_send_enable, 0);
    chk("disp_robid", send_robid, 3);
    chk("disp_vj", vj, 5);
    chk("disp_vk", vk, 7);
    chk("disp_pc", out_pc, 100);
    tick();
    #1;
    chk("empty_after", rob_send_enable, 0);
    chk("empty_pc", out_pc, 0);

    // Routing at the load/store range edges.
    set_in(6'(LSLO), 32'd200, 1, 0, 0, 1, 0, 0);
    tick();
    set_in(6'(LSHI + 1), 32'd204, 1, 0, 0, 1, 0, 0);
    #1;
    chk("route_lo_slb", slb_send_enable, 1);
    chk("route_lo_rs", rs_send_enable, 0);
    tick();
    in_valid = 0;
    #1;
    chk("route_hi_slb", slb_send_enable, 0);
    chk("route_hi_rs", rs_send_enable, 1);
    chk("route_hi_pc", out_pc, 204);
    tick();

    // Operand resolution table: enqueue, then check the dispatched operands.
    for (int i = 0; i < 8; i++) begin
      set_in(6'd1, 32'h300 + i, vecs[i].rf_r, vecs[i].rf_v, 4'd3, vecs[i].rf_r, vecs[i].rf_v, 4'd3);
      rob_rs1_ready = vecs[i].rob_r; rob_rs1_value = vecs[i].rob_v;
      rob_rs2_ready = vecs[i].rob_r; rob_rs2_value = vecs[i].rob_v;
      set_cdb(vecs[i].cv, vecs[i].t0, vecs[i].c0, vecs[i].t1, vecs[i].c1);
      tick();
      in_valid = 0;
      set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      #1;
      chk($sformatf("vec%0d_rj", i), rj, vecs[i].exp_r);
      chk($sformatf("vec%0d_vj", i), vj, vecs[i].exp_v);
      chk($sformatf("vec%0d_rk", i), rk, vecs[i].exp_r);
      chk($sformatf("vec%0d_vk", i), vk, vecs[i].exp_v);
      $display("vec %0d: rj=%0d vj=%0h", i, rj, vj);
      tick();
    end
    rob_rs1_ready = 0; rob_rs2_ready = 0;

    // Backpressure fills the queue; release gives 4 back-to-back dispatches.
    rs_full = 1;
    for (int i = 0; i < 4; i++) begin
      set_in(6'd1, 32'd400 + 4 * i, 1, i, 0, 1, 0, 0);
      #1;
      chk($sformatf("bp_ready%0d", i), in_ready, 1);
      chk($sformatf("bp_stall%0d", i), rob_send_enable, 0);
      tick();
    end
    set_in(6'd1, 32'd416, 1, 0, 0, 1, 0, 0);
    #1;
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_strobe", rs_send_enable, 0);
    chk("bp_head_pc", out_pc, 400);
    tick();
    in_valid = 0; rs_full = 0;
    for (int i = 0; i < 4; i++) begin
      next_robid = 4'(5 + i);
      #1;
      chk($sformatf("bp_go%0d", i), rs_send_enable, 1);
      chk($sformatf("bp_robid%0d", i), send_robid, 5 + i);
      chk($sformatf("bp_pc%0d", i), out_pc, 400 + 4 * i);
      tick();
    end
    #1;
    chk("bp_drained", rob_send_enable, 0);

    // CDB snoop while stalled; bus 0 carries an unrelated tag.
    rob_full = 1;
    set_in(6'd1, 32'd500, 0, 32'h1111, 4'd2, 1, 32'd9, 4'd0);
    rob_rs1_value = 32'h2222;
    tick();
    in_valid = 0;
    #1;
    chk("snoop_wait_rj", rj, 0);
    chk("snoop_wait_vj", vj, 32'h2222);
    chk("snoop_qj", qj, 2);
    tick();
    set_cdb(2'b11, 4'd5, 32'hBEEF, 4'd2, 32'hDEAD);
    #1;
    chk("snoop_byp_rj", rj, 1);
    chk("snoop_byp_vj", vj, 32'hDEAD);
    tick();
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    #1;
    chk("snoop_cap_rj", rj, 1);
    chk("snoop_cap_vj", vj, 32'hDEAD);
    rob_full = 0;
    #1;
    chk("snoop_disp", rob_send_enable, 1);
    tick();
    // Broadcast arriving in the dispatch cycle itself.
    set_in(6'd1, 32'd504, 0, 32'h1111, 4'd2, 1, 32'd9, 4'd0);
    tick();
    in_valid = 0;
    set_cdb(2'b10, 4'd0, 32'd0, 4'd2, 32'hDEAD);
    #1;
    chk("snoop_dc_go", rob_send_enable, 1);
    chk("snoop_dc_rj", rj, 1);
    chk("snoop_dc_vj", vj, 32'hDEAD);
    tick();
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);

    // Flush with 3 entries queued.
    rs_full = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(6'd1, 32'd600 + 4 * i, 1, 0, 0, 1, 0, 0);
      tick();
    end
    rs_full = 0; flush = 1;
    set_in(6'd1, 32'd612, 1, 0, 0, 1, 0, 0);
    #1;
    chk("flush_rob", rob_send_enable, 0);
    chk("flush_rs", rs_send_enable, 0);
    chk("flush_ready", in_ready, 0);
    tick();
    flush = 0; in_valid = 0;
    #1;
    chk("flush_empty", rob_send_enable, 0);
    chk("flush_pc", out_pc, 0);

    // rdy=0 freezes everything, including CDB snoop.
    rob_full = 1;
    set_in(6'd1, 32'd700, 0, 0, 4'd6, 1, 0, 0);
    tick();
    set_in(6'd1, 32'd704, 1, 1, 0, 1, 0, 0);
    tick();
    rdy = 0; rob_full = 0;
    set_in(6'd1, 32'd708, 1, 0, 0, 1, 0, 0);
    set_cdb(2'b01, 4'd6, 32'h77, 4'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("frz_rob%0d", i), rob_send_enable, 0);
      chk($sformatf("frz_ready%0d", i), in_ready, 0);
      tick();
    end
    rdy = 1; in_valid = 0; rob_full = 1;
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    #1;
    chk("frz_no_snoop", rj, 0);
    chk("frz_head", out_pc, 700);
    rob_full = 0;
    #1;
    chk("frz_go0", rob_send_enable, 1);
    tick();
    #1;
    chk("frz_go1_pc", out_pc, 704);
    chk("frz_go1", rob_send_enable, 1);
    tick();
    #1;
    chk("frz_done", rob_send_enable, 0);

    // Randomised streaming against a queue model.
    rst = 0;
    tick();
    mq.delete();
    seq = 32'h1000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom % 60) != 0;
      rdy = ($urandom % 10) != 0;
      flush = ($urandom % 40) == 0;
      in_valid = ($urandom % 3) != 0;
      in_op = 6'($urandom % 24); in_rd = 5'($urandom); in_imm = $urandom; in_pc = seq;
      seq = seq + 1;
      in_rj = $urandom % 2; in_vj = $urandom; in_qj = 4'($urandom % 4);
      in_rk = $urandom % 2; in_vk = $urandom; in_qk = 4'($urandom % 4);
      rob_rs1_ready = ($urandom % 4) == 0; rob_rs1_value = $urandom;
      rob_rs2_ready = ($urandom % 4) == 0; rob_rs2_value = $urandom;
      set_cdb(2'($urandom), 4'($urandom % 4), $urandom, 4'($urandom % 4), $urandom);
      rob_full = ($urandom % 4) == 0; rs_full = ($urandom % 4) == 0;
      slb_full = ($urandom % 4) == 0; next_robid = 4'($urandom);
      #1;
      m_live = rst && (mq.size() != 0);
      m_go = 0; m_ls = 0;
      if (m_live) begin
        hd = mq[0];
        hj = ref_cdb(hd.qj); hk = ref_cdb(hd.qk);
        m_ls = (hd.op >= LSLO) && (hd.op <= LSHI);
        m_go = rdy && !flush && !rob_full && (m_ls ? !slb_full : !rs_full);
        chk("rnd_pc", out_pc, hd.pc);
        chk("rnd_op", out_op, hd.op);
        chk("rnd_imm", out_imm, hd.imm);
        chk("rnd_qj", qj, hd.qj);
        chk("rnd_rj", rj, hd.rj | hj[32]);
        chk("rnd_vj", vj, (hd.rj || !hj[32]) ? hd.vj : hj[31:0]);
        chk("rnd_rk", rk, hd.rk | hk[32]);
        chk("rnd_vk", vk, (hd.rk || !hk[32]) ? hd.vk : hk[31:0]);
      end else begin
        chk("rnd_idle_pc", out_pc, 0);
      end
      m_rdy = rst && rdy && !flush && (mq.size() < DEPTH);
      chk("rnd_in_ready", in_ready, m_rdy);
      chk("rnd_rob", rob_send_enable, m_go);
      chk("rnd_rs", rs_send_enable, m_go && !m_ls);
      chk("rnd_slb", slb_send_enable, m_go && m_ls);
      chk("rnd_robid", send_robid, m_go ? next_robid : 4'd0);
      if (m_go) $display("cycle %0d: dispatch pc=%0h robid=%0d", cyc, out_pc, send_robid);
      if (!rst || (rdy && flush)) begin
        mq.delete();
      end else if (rdy) begin
        for (int i = 0; i < mq.size(); i++) begin
          t = mq[i];
          h = ref_cdb(t.qj);
          if (!t.rj && h[32]) begin t.rj = 1; t.vj = h[31:0]; end
          h = ref_cdb(t.qk);
          if (!t.rk && h[32]) begin t.rk = 1; t.vk = h[31:0]; end
          mq[i] = t;
        end
        if (m_go) void'(mq.pop_front());
        if (m_rdy && in_valid) begin
          nr.op = in_op; nr.rd = in_rd; nr.imm = in_imm; nr.pc = in_pc;
          nr.qj = in_qj; nr.qk = in_qk;
          nr.rj = in_rj | rob_rs1_ready; nr.vj = in_rj ? in_vj : rob_rs1_value;
          nr.rk = in_rk | rob_rs2_ready; nr.vk = in_rk ? in_vk : rob_rs2_value;
          h = ref_cdb(in_qj);
          if (!nr.rj && h[32]) begin nr.rj = 1; nr.vj = h[31:0]; end
          h = ref_cdb(in_qk);
          if (!nr.rk && h[32]) begin nr.rk = 1; nr.vk = h[31:0]; end
          mq.push_back(nr);
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
